// File: rtl/prbs_checker.sv
// prbs_checker
//   Receive-side checker for the serial PRBS-8 pattern
//   b[n] = b[n-8] ^ b[n-6] ^ b[n-5] ^ b[n-4]  (x^8+x^6+x^5+x^4+1, period 255).
//
//   The checker seeds its history register from the first 8 valid bits, then
//   self-synchronises by predicting each incoming bit from the history.  After
//   LOCK_CNT consecutive correct predictions it declares lock and switches to
//   a flywheel: the history is fed with its own predictions, so one corrupted
//   line bit is counted exactly once.  Too many errors inside one observation
//   window of WINDOW valid bits drops lock and returns to synchronisation.
//
//   Handshake: in_bit is consumed on every rising edge where in_valid=1.
//   There is no back-pressure.  Cycles with in_valid=0 change no state and
//   produce no pulses.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   in_bit is valid this cycle
//   in_bit     received serial PRBS bit
//   clr_cnt    synchronous clear of err_count
//   locked     checker is locked to the pattern
//   err_pulse  one-cycle pulse per bit error detected while locked
//   lock_lost  one-cycle pulse when lock is dropped
//   err_count  saturating count of errors detected while locked
module prbs_checker #(
  parameter int LOCK_CNT    = 16,
  parameter int WINDOW      = 64,
  parameter int LOSS_THRESH = 4,
  parameter int ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic             lock_lost,
  output logic [ERR_W-1:0] err_count
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int EW = $clog2(LOSS_THRESH + 1);

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [7:0]       s, s_n;
  logic [2:0]       seed_cnt, seed_cnt_n;
  logic [GW-1:0]    good_cnt, good_cnt_n;
  logic [WW-1:0]    win_cnt, win_cnt_n;
  logic [EW-1:0]    win_err, win_err_n;
  logic             locked_n, err_pulse_n, lock_lost_n;
  logic [ERR_W-1:0] err_count_n;

  logic pred;
  logic mismatch;
  logic count_err;

  assign pred     = s[7] ^ s[5] ^ s[4] ^ s[3];
  assign mismatch = in_bit ^ pred;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEED;
      s         <= '0;
      seed_cnt  <= '0;
      good_cnt  <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      lock_lost <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_n;
      s         <= s_n;
      seed_cnt  <= seed_cnt_n;
      good_cnt  <= good_cnt_n;
      win_cnt   <= win_cnt_n;
      win_err   <= win_err_n;
      locked    <= locked_n;
      err_pulse <= err_pulse_n;
      lock_lost <= lock_lost_n;
      err_count <= err_count_n;
    end
  end

  always_comb begin
    state_n     = state;
    s_n         = s;
    seed_cnt_n  = seed_cnt;
    good_cnt_n  = good_cnt;
    win_cnt_n   = win_cnt;
    win_err_n   = win_err;
    locked_n    = locked;
    // Pulses are cleared on every edge, including invalid cycles, so they
    // never stretch across an in_valid gap.
    err_pulse_n = 1'b0;
    lock_lost_n = 1'b0;
    count_err   = 1'b0;

    if (in_valid) begin
      case (state)
        SEED: begin
          s_n        = {s[6:0], in_bit};
          seed_cnt_n = seed_cnt + 3'd1;
          if (seed_cnt == 3'd7) begin
            state_n    = SYNC;
            seed_cnt_n = '0;
            good_cnt_n = '0;
          end
        end

        SYNC: begin
          s_n = {s[6:0], in_bit};
          // An all-zero history predicts zero forever; never credit it.
          if (s == 8'd0 || mismatch) begin
            good_cnt_n = '0;
          end else if (good_cnt == GW'(LOCK_CNT - 1)) begin
            state_n    = LOCKED;
            locked_n   = 1'b1;
            good_cnt_n = '0;
            win_cnt_n  = '0;
            win_err_n  = '0;
          end else begin
            good_cnt_n = good_cnt + GW'(1);
          end
        end

        LOCKED: begin
          // Flywheel: history follows the prediction, not the line.
          s_n         = {s[6:0], pred};
          count_err   = mismatch;
          err_pulse_n = mismatch;
          if (win_cnt == WW'(WINDOW - 1)) begin
            // New window starts; an error on the wrap bit opens it at 1.
            win_cnt_n = '0;
            win_err_n = EW'(mismatch);
          end else begin
            win_cnt_n = win_cnt + WW'(1);
            win_err_n = win_err + EW'(mismatch);
          end
          if (mismatch && win_err_n == EW'(LOSS_THRESH)) begin
            state_n     = SYNC;
            locked_n    = 1'b0;
            lock_lost_n = 1'b1;
            good_cnt_n  = '0;
          end
        end

        default: begin
          state_n = SEED;
        end
      endcase
    end
  end

  // The clear wins over the stored value but not over an error counted on
  // the same edge, which leaves exactly one error recorded.
  always_comb begin
    err_count_n = err_count;
    if (clr_cnt) begin
      err_count_n = count_err ? ERR_W'(1) : '0;
    end else if (count_err && err_count != {ERR_W{1'b1}}) begin
      err_count_n = err_count + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker
//   Directed bench for prbs_checker.  A reference PRBS-8 generator (seed 0x01)
//   produces the line stream; selected bits are inverted to create errors.
//   Two instances share all inputs: dut (ERR_W=16) and dut4 (ERR_W=4) for
//   the saturation case.  Outputs are sampled 1 time unit after the edge.
module tb_prbs_checker;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_bit;
  logic        clr_cnt;
  logic        locked, err_pulse, lock_lost;
  logic [15:0] err_count;
  logic        locked4, err_pulse4, lock_lost4;
  logic [3:0]  err_count4;

  logic [7:0]  g;
  int          errors;
  int          checks;
  int          pulse_cnt;
  int          lost_cnt;
  int          gap_bad;
  logic [15:0] exp_q[$];

  prbs_checker #(.LOCK_CNT(16), .WINDOW(64), .LOSS_THRESH(4), .ERR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
    .clr_cnt(clr_cnt), .locked(locked), .err_pulse(err_pulse),
    .lock_lost(lock_lost), .err_count(err_count)
  );

  prbs_checker #(.LOCK_CNT(16), .WINDOW(64), .LOSS_THRESH(4), .ERR_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
    .clr_cnt(clr_cnt), .locked(locked4), .err_pulse(err_pulse4),
    .lock_lost(lock_lost4), .err_count(err_count4)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    in_valid = 1'b0;
    clr_cnt  = 1'b0;
    in_bit   = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    g = 8'h01;
  endtask

  // ---------------- driver tasks ----------------
  task automatic gen_bit(output logic b);
    b = g[7] ^ g[5] ^ g[4] ^ g[3];
    g = {g[6:0], b};
  endtask

  task automatic drive(input logic b, input logic v, input logic clr);
    in_bit   = b;
    in_valid = v;
    clr_cnt  = clr;
    @(posedge clk);
    #1;
    if (err_pulse) pulse_cnt++;
    if (lock_lost) lost_cnt++;
    if (!v && (err_pulse || lock_lost)) gap_bad++;
    in_valid = 1'b0;
    clr_cnt  = 1'b0;
  endtask

  task automatic send_clean(input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      gen_bit(b);
      drive(b, 1'b1, 1'b0);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%b exp=0", locked); end
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_err_pulse got=%b exp=0", err_pulse); end
    checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL reset_lock_lost got=%b exp=0", lock_lost); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
    checks++; if (err_count4 !== 4'd0) begin errors++; $display("FAIL reset_err_count4 got=%0d exp=0", err_count4); end
  endtask

  task automatic test_clean_lock();
    logic b;
    int lock_at;
    do_reset();
    lock_at = 0; pulse_cnt = 0; lost_cnt = 0;
    for (int i = 1; i <= 24 + 500; i++) begin
      gen_bit(b);
      drive(b, 1'b1, 1'b0);
      if (locked && lock_at == 0) lock_at = i;
    end
    checks++; if (lock_at !== 24) begin errors++; $display("FAIL clean_lock_point got=%0d exp=24", lock_at); end
    checks++; if (pulse_cnt !== 0) begin errors++; $display("FAIL clean_pulses got=%0d exp=0", pulse_cnt); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL clean_err_count got=%0d exp=0", err_count); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL clean_locked got=%b exp=1", locked); end
  endtask

  task automatic test_single_error();
    logic b;
    pulse_cnt = 0; lost_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      gen_bit(b);
      drive(b ^ (i == 10), 1'b1, 1'b0);
      if (i == 10) begin
        checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL single_pulse got=%b exp=1", err_pulse); end
      end
      if (i == 11) begin
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL single_pulse_width got=%b exp=0", err_pulse); end
      end
    end
    checks++; if (pulse_cnt !== 1) begin errors++; $display("FAIL single_pulse_count got=%0d exp=1", pulse_cnt); end
    checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL single_err_count got=%0d exp=1", err_count); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL single_locked got=%b exp=1", locked); end
    checks++; if (lost_cnt !== 0) begin errors++; $display("FAIL single_lost got=%0d exp=0", lost_cnt); end
  endtask

  task automatic test_loss();
    logic b;
    logic bad;
    int relock_at;
    do_reset();
    send_clean(24);
    pulse_cnt = 0; lost_cnt = 0; relock_at = 0;
    for (int i = 1; i <= 100; i++) begin
      gen_bit(b);
      bad = (i == 5) || (i == 10) || (i == 15) || (i == 20);
      drive(b ^ bad, 1'b1, 1'b0);
      if (i == 15) begin
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL loss_locked_3err got=%b exp=1", locked); end
      end
      if (i == 20) begin
        checks++; if (lock_lost !== 1'b1) begin errors++; $display("FAIL loss_pulse got=%b exp=1", lock_lost); end
        checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL loss_err_pulse got=%b exp=1", err_pulse); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL loss_locked got=%b exp=0", locked); end
        checks++; if (err_count !== 16'd4) begin errors++; $display("FAIL loss_err_count got=%0d exp=4", err_count); end
      end
      if (i > 20 && locked && relock_at == 0) relock_at = i - 20;
    end
    checks++; if (relock_at !== 16) begin errors++; $display("FAIL relock_point got=%0d exp=16", relock_at); end
    checks++; if (err_count !== 16'd4) begin errors++; $display("FAIL relock_err_count got=%0d exp=4", err_count); end
    checks++; if (lost_cnt !== 1) begin errors++; $display("FAIL loss_lost_count got=%0d exp=1", lost_cnt); end
    checks++; if (pulse_cnt !== 4) begin errors++; $display("FAIL loss_pulse_count got=%0d exp=4", pulse_cnt); end
  endtask

  task automatic test_no_lock();
    int seen;
    do_reset();
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      if (locked) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL zeros_locked got=%0d exp=0", seen); end
    do_reset();
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      if (locked) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL ones_locked got=%0d exp=0", seen); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL ones_err_count got=%0d exp=0", err_count); end
  endtask

  task automatic test_gaps();
    logic b;
    logic v;
    logic bad;
    logic force_gap;
    logic [15:0] exp_idx;
    int vcount;
    int lock_at;
    int cycles;
    do_reset();
    vcount = 0; lock_at = 0; cycles = 0; gap_bad = 0; pulse_cnt = 0;
    force_gap = 1'b0;
    exp_q.delete();
    while (vcount < 24 + 300 && cycles < 5000) begin
      cycles++;
      v = force_gap ? 1'b0 : 1'($urandom_range(0, 1));
      force_gap = 1'b0;
      bad = 1'b0;
      b = 1'b0;
      if (v) begin
        gen_bit(b);
        vcount++;
        bad = (vcount == 44) || (vcount == 124) || (vcount == 204);
        if (bad) begin
          exp_q.push_back(16'(vcount));
          force_gap = 1'b1;
        end
      end
      drive(b ^ bad, v, 1'b0);
      if (v && err_pulse) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL gap_unexpected_pulse at_bit=%0d exp=none", vcount);
        end else begin
          exp_idx = exp_q.pop_front();
          if (exp_idx !== 16'(vcount)) begin
            errors++; $display("FAIL gap_pulse_bit got=%0d exp=%0d", vcount, exp_idx);
          end
        end
      end
      if (locked && lock_at == 0) lock_at = vcount;
    end
    checks++; if (vcount !== 324) begin errors++; $display("FAIL gap_timeout got=%0d exp=324", vcount); end
    checks++; if (lock_at !== 24) begin errors++; $display("FAIL gap_lock_point got=%0d exp=24", lock_at); end
    checks++; if (gap_bad !== 0) begin errors++; $display("FAIL gap_pulse_on_invalid got=%0d exp=0", gap_bad); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL gap_missing_pulses got=%0d exp=0", exp_q.size()); end
    checks++; if (err_count !== 16'd3) begin errors++; $display("FAIL gap_err_count got=%0d exp=3", err_count); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL gap_locked got=%b exp=1", locked); end
  endtask

  task automatic test_saturation();
    logic b;
    do_reset();
    send_clean(24);
    lost_cnt = 0;
    // One error per 64-bit window at offset 10: 20 errors in 1280 bits.
    for (int i = 1; i <= 1280; i++) begin
      gen_bit(b);
      drive(b ^ ((i % 64) == 10), 1'b1, 1'b0);
    end
    checks++; if (err_count4 !== 4'd15) begin errors++; $display("FAIL sat_err_count4 got=%0d exp=15", err_count4); end
    checks++; if (err_count !== 16'd20) begin errors++; $display("FAIL sat_err_count got=%0d exp=20", err_count); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL sat_locked got=%b exp=1", locked); end
    checks++; if (lost_cnt !== 0) begin errors++; $display("FAIL sat_lost got=%0d exp=0", lost_cnt); end
  endtask

  task automatic test_clr_coincide();
    logic b;
    gen_bit(b);
    drive(~b, 1'b1, 1'b1);
    checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL clr_err_count got=%0d exp=1", err_count); end
    checks++; if (err_count4 !== 4'd1) begin errors++; $display("FAIL clr_err_count4 got=%0d exp=1", err_count4); end
    checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL clr_err_pulse got=%b exp=1", err_pulse); end
    gen_bit(b);
    drive(b, 1'b1, 1'b1);
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL clr_plain got=%0d exp=0", err_count); end
  endtask

  task automatic test_reset_mid();
    logic b;
    int lock_at;
    gen_bit(b);
    drive(~b, 1'b1, 1'b0);
    checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL mid_pre_err_count got=%0d exp=1", err_count); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL mid_pre_locked got=%b exp=1", locked); end
    rst_n = 1'b0;
    #2;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL mid_locked got=%b exp=0", locked); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL mid_err_count got=%0d exp=0", err_count); end
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL mid_err_pulse got=%b exp=0", err_pulse); end
    #2;
    rst_n = 1'b1;
    // Stream continues from where it was; the checker must reseed.
    lock_at = 0;
    for (int i = 1; i <= 40; i++) begin
      gen_bit(b);
      drive(b, 1'b1, 1'b0);
      if (locked && lock_at == 0) lock_at = i;
    end
    checks++; if (lock_at !== 24) begin errors++; $display("FAIL mid_relock_point got=%0d exp=24", lock_at); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    errors = 0; checks = 0;
    pulse_cnt = 0; lost_cnt = 0; gap_bad = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; clr_cnt = 1'b0;
    g = 8'h01;
    test_reset();
    test_clean_lock();
    test_single_error();
    test_loss();
    test_no_lock();
    test_gaps();
    test_saturation();
    test_clr_coincide();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
